// File: rtl/oric_tap_player.sv
// Oric-format TAP cassette player: fetches bytes from the tape cache and
// serialises each as a start/data/parity/stop frame of square-wave pulses.
module oric_tap_player #(
    parameter int ADDR_W    = 16,
    parameter int HALF1     = 5000,
    parameter int HALF0     = 10000,
    parameter int STOP_BITS = 3,
    parameter int LOOP      = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rewind,
    input  logic              en,
    input  logic [ADDR_W-1:0] tape_end,
    output logic [ADDR_W-1:0] tape_addr,
    input  logic [7:0]        tape_data,
    output logic              data,
    output logic              busy,
    output logic              eot
);

    localparam int FRAME_W = 10 + STOP_BITS;
    localparam int HMAX    = (HALF0 > HALF1) ? HALF0 : HALF1;
    localparam int TMR_W   = (HMAX > 1) ? $clog2(HMAX) : 1;
    localparam int CNT_W   = $clog2(FRAME_W + 1);

    localparam logic [TMR_W-1:0] H1_LD = TMR_W'(HALF1 - 1);
    localparam logic [TMR_W-1:0] H0_LD = TMR_W'(HALF0 - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_HI,
        S_LO,
        S_DONE
    } state_t;

    state_t             r_state;
    logic [TMR_W-1:0]   r_timer;
    logic [FRAME_W-1:0] r_frame;
    logic [CNT_W-1:0]   r_bits;

    function automatic logic [TMR_W-1:0] half_load(input logic bit_val);
        return bit_val ? H1_LD : H0_LD;
    endfunction

    // Frame is shifted out LSB first: start(0), data[0..7], odd parity, stop 1s.
    function automatic logic [FRAME_W-1:0] make_frame(input logic [7:0] d);
        return {{STOP_BITS{1'b1}}, ~^d, d, 1'b0};
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tape_addr <= '0;
            data      <= 1'b0;
            busy      <= 1'b0;
            eot       <= 1'b0;
            r_state   <= S_IDLE;
            r_timer   <= '0;
            r_frame   <= '0;
            r_bits    <= '0;
        end else if (rewind) begin
            tape_addr <= '0;
            data      <= 1'b0;
            busy      <= 1'b0;
            eot       <= 1'b0;
            r_state   <= S_IDLE;
            r_timer   <= '0;
            r_frame   <= '0;
            r_bits    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (en && !eot) r_state <= S_FETCH;
                end
                S_FETCH: begin
                    r_state <= S_LOAD;
                end
                S_LOAD: begin
                    r_frame <= make_frame(tape_data);
                    r_bits  <= CNT_W'(FRAME_W);
                    r_timer <= H0_LD;
                    data    <= 1'b1;
                    busy    <= 1'b1;
                    r_state <= S_HI;
                end
                // Pause only freezes the pulse phases; fetch/load always run to HI.
                S_HI: begin
                    if (en) begin
                        if (r_timer == '0) begin
                            r_timer <= half_load(r_frame[0]);
                            data    <= 1'b0;
                            r_state <= S_LO;
                        end else begin
                            r_timer <= r_timer - TMR_W'(1);
                        end
                    end
                end
                S_LO: begin
                    if (en) begin
                        if (r_timer != '0) begin
                            r_timer <= r_timer - TMR_W'(1);
                        end else if (r_bits > CNT_W'(1)) begin
                            r_frame <= r_frame >> 1;
                            r_bits  <= r_bits - CNT_W'(1);
                            r_timer <= half_load(r_frame[1]);
                            data    <= 1'b1;
                            r_state <= S_HI;
                        end else begin
                            r_frame <= r_frame >> 1;
                            r_bits  <= '0;
                            busy    <= 1'b0;
                            if (tape_addr == tape_end) begin
                                r_state <= S_DONE;
                            end else begin
                                tape_addr <= tape_addr + ADDR_W'(1);
                                r_state   <= S_FETCH;
                            end
                        end
                    end
                end
                S_DONE: begin
                    if (LOOP != 0) begin
                        tape_addr <= '0;
                        r_state   <= S_FETCH;
                    end else begin
                        eot     <= 1'b1;
                        data    <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_oric_tap_player.sv
// Bench for oric_tap_player: expected per-cycle waveforms are generated from
// the byte contents and pulse-timing rules, then compared cycle by cycle.
module tb_oric_tap_player;

    localparam int AW = 4;
    localparam int H1 = 4;
    localparam int H0 = 8;
    localparam int SB = 3;
    localparam int FW = 10 + SB;

    typedef struct packed {
        logic          d;
        logic          b;
        logic [AW-1:0] a;
        logic          e;
    } rec_t;

    logic          clk   = 1'b0;
    logic          reset = 1'b1;
    logic          rw_a  = 1'b0;
    logic          rw_b  = 1'b0;
    logic          en_a  = 1'b0;
    logic          en_b  = 1'b0;
    logic [AW-1:0] te_a  = '0;
    logic [AW-1:0] te_b  = '0;
    logic [AW-1:0] addr_a, addr_b;
    logic [7:0]    td_a, td_b;
    logic          data_a, busy_a, eot_a;
    logic          data_b, busy_b, eot_b;
    logic [7:0]    mem [16];

    rec_t q[$];
    logic dec[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   busy_cnt;
    int   eot_at;

    always #5 clk = ~clk;

    // Tape cache model: one-clock read latency for each player.
    always @(posedge clk) begin
        td_a <= mem[addr_a];
        td_b <= mem[addr_b];
    end

    oric_tap_player #(.ADDR_W(AW), .HALF1(H1), .HALF0(H0), .STOP_BITS(SB), .LOOP(0)) u_a (
        .clk(clk), .reset(reset), .rewind(rw_a), .en(en_a), .tape_end(te_a),
        .tape_addr(addr_a), .tape_data(td_a), .data(data_a), .busy(busy_a), .eot(eot_a)
    );

    oric_tap_player #(.ADDR_W(AW), .HALF1(H1), .HALF0(H0), .STOP_BITS(SB), .LOOP(1)) u_b (
        .clk(clk), .reset(reset), .rewind(rw_b), .en(en_b), .tape_end(te_b),
        .tape_addr(addr_b), .tape_data(td_b), .data(data_b), .busy(busy_b), .eot(eot_b)
    );

    function automatic rec_t mk(input logic d, input logic b, input int a, input logic e);
        rec_t r;
        r.d = d;
        r.b = b;
        r.a = a[AW-1:0];
        r.e = e;
        return r;
    endfunction

    function automatic rec_t get_obs(input int sel);
        if (sel == 0) return mk(data_a, busy_a, int'(addr_a), eot_a);
        return mk(data_b, busy_b, int'(addr_b), eot_b);
    endfunction

    function automatic logic frame_bit(input logic [7:0] v, input int i);
        if (i == 0) return 1'b0;
        if (i <= 8) return v[i-1];
        if (i == 9) return ($countones(v) % 2) == 0;
        return 1'b1;
    endfunction

    task automatic set_rw(input int sel, input logic v);
        if (sel == 0) rw_a = v; else rw_b = v;
    endtask

    task automatic set_en(input int sel, input logic v);
        if (sel == 0) en_a = v; else en_b = v;
    endtask

    task automatic set_te(input int sel, input logic [AW-1:0] v);
        if (sel == 0) te_a = v; else te_b = v;
    endtask

    // Expected waveform from the cycle after a rewind: one idle cycle, then per
    // byte 2 fetch/load cycles plus 2*HALFx cycles per frame bit.
    task automatic build(input int last, input bit loop, input int max_recs);
        int a = 0;
        bit fin = 0;
        q.delete();
        q.push_back(mk(0, 0, 0, 0));
        while (!fin && q.size() < max_recs) begin
            repeat (2) q.push_back(mk(0, 0, a, 0));
            for (int i = 0; i < FW; i++) begin
                int h = frame_bit(mem[a], i) ? H1 : H0;
                repeat (h) q.push_back(mk(1, 1, a, 0));
                repeat (h) q.push_back(mk(0, 1, a, 0));
            end
            if (a == last) begin
                q.push_back(mk(0, 0, a, 0));
                if (loop) a = 0;
                else begin
                    repeat (4) q.push_back(mk(0, 0, a, 1));
                    fin = 1;
                end
            end else begin
                a = (a + 1) % 16;
            end
        end
        while (q.size() > max_recs) void'(q.pop_back());
    endtask

    task automatic run(input string name, input int sel, input bit do_rw, input int pause_at,
                       input int pause_len, input int te_at, input logic [AW-1:0] te_new);
        int   bad = 0;
        int   first = -1;
        int   hl = 0;
        rec_t obs, exp_f, obs_f;
        if (do_rw) begin
            @(negedge clk);
            set_rw(sel, 1'b1);
            set_en(sel, 1'b1);
            @(negedge clk);
        end
        set_rw(sel, 1'b0);
        dec.delete();
        busy_cnt = 0;
        eot_at = -1;
        for (int i = 0; i < q.size(); i++) begin
            obs = get_obs(sel);
            if (obs !== q[i]) begin
                if (bad == 0) begin first = i; exp_f = q[i]; obs_f = obs; end
                bad++;
            end
            if (obs.b) busy_cnt++;
            if (obs.e && eot_at < 0) eot_at = i;
            if (obs.d) hl++;
            else if (hl > 0) begin dec.push_back(hl == H1); hl = 0; end
            if (i == te_at) set_te(sel, te_new);
            if (i == pause_at) begin
                set_en(sel, 1'b0);
                for (int k = 0; k < pause_len; k++) begin
                    @(negedge clk);
                    obs = get_obs(sel);
                    if (obs !== q[i]) begin
                        if (bad == 0) begin first = i; exp_f = q[i]; obs_f = obs; end
                        bad++;
                    end
                end
                set_en(sel, 1'b1);
            end
            @(negedge clk);
        end
        n_cmp++;
        if (bad !== 0) begin
            n_bad++;
            $display("FAIL %s: %0d cycles differ, first at cycle %0d got d/b/a/e=%b/%b/%0d/%b required %b/%b/%0d/%b",
                     name, bad, first, obs_f.d, obs_f.b, obs_f.a, obs_f.e, exp_f.d, exp_f.b, exp_f.a, exp_f.e);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (addr_a !== '0) begin n_bad++; $display("FAIL reset_addr: got %0d required 0", addr_a); end
        n_cmp++; if (data_a !== 1'b0) begin n_bad++; $display("FAIL reset_data: got %b required 0", data_a); end
        n_cmp++; if (busy_a !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b required 0", busy_a); end
        n_cmp++; if (eot_a !== 1'b0) begin n_bad++; $display("FAIL reset_eot: got %b required 0", eot_a); end
        reset = 1'b0;
    endtask

    task automatic test_single_byte();
        logic [FW-1:0] w;
        logic [FW-1:0] want;
        rec_t obs;
        want = 'h1C2C;
        mem[0] = 8'h16;
        te_a = '0;
        build(0, 0, 100000);
        run("single_byte", 0, 1, -1, 0, -1, '0);
        w = '0;
        for (int i = 0; i < FW && i < dec.size(); i++) w[i] = dec[i];
        n_cmp++;
        if (dec.size() != FW || w !== want) begin
            n_bad++;
            $display("FAIL single_frame: got %0d bits %h required %0d bits %h", dec.size(), w, FW, want);
        end
        set_en(0, 1'b0);
        repeat (5) @(negedge clk);
        set_en(0, 1'b1);
        repeat (30) @(negedge clk);
        obs = get_obs(0);
        n_cmp++;
        if (obs !== mk(0, 0, 0, 1)) begin
            n_bad++;
            $display("FAIL eot_sticky: got d/b/a/e=%b/%b/%0d/%b required 0/0/0/1", obs.d, obs.b, obs.a, obs.e);
        end
        rw_a = 1'b1;
        en_a = 1'b0;
        @(negedge clk);
        rw_a = 1'b0;
        repeat (5) @(negedge clk);
        obs = get_obs(0);
        n_cmp++;
        if (obs !== mk(0, 0, 0, 0)) begin
            n_bad++;
            $display("FAIL rewind_clears_eot: got d/b/a/e=%b/%b/%0d/%b required 0/0/0/0", obs.d, obs.b, obs.a, obs.e);
        end
    endtask

    task automatic test_timing();
        mem[0] = 8'hFF;
        te_a = '0;
        build(0, 0, 100000);
        run("timing_ff", 0, 1, -1, 0, -1, '0);
        n_cmp++;
        if (busy_cnt !== 2 * H0 + 12 * 2 * H1) begin
            n_bad++;
            $display("FAIL timing_busy_len: got %0d required %0d", busy_cnt, 2 * H0 + 12 * 2 * H1);
        end
        n_cmp++;
        if (eot_at !== 1 + 2 + 2 * H0 + 12 * 2 * H1 + 1) begin
            n_bad++;
            $display("FAIL timing_eot_cycle: got %0d required %0d", eot_at, 1 + 2 + 2 * H0 + 12 * 2 * H1 + 1);
        end
    endtask

    task automatic test_random_tapes();
        for (int t = 0; t < 3; t++) begin
            int last = $urandom_range(1, 3);
            for (int a = 0; a <= last; a++) mem[a] = 8'($urandom);
            te_a = AW'(last);
            build(last, 0, 100000);
            run($sformatf("random_tape_%0d", t), 0, 1, -1, 0, -1, '0);
        end
    endtask

    task automatic test_pause();
        int pa;
        mem[0] = 8'($urandom);
        mem[1] = 8'($urandom);
        te_a = AW'(1);
        build(1, 0, 100000);
        pa = $urandom_range(10, 150);
        while (pa < q.size() && !(q[pa].d && q[pa].b)) pa++;
        run("pause_hi", 0, 1, pa, 100, -1, '0);
    endtask

    task automatic test_pause_fetch();
        int n = 0;
        mem[0] = 8'($urandom);
        te_a = '0;
        @(negedge clk);
        rw_a = 1'b1;
        en_a = 1'b1;
        @(negedge clk);
        rw_a = 1'b0;
        @(negedge clk);
        en_a = 1'b0;
        repeat (10) @(negedge clk);
        n_cmp++;
        if ({data_a, busy_a} !== 2'b11) begin
            n_bad++;
            $display("FAIL pause_fetch_hold: got data/busy=%b/%b required 1/1", data_a, busy_a);
        end
        en_a = 1'b1;
        @(negedge clk);
        while (data_a === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        n_cmp++;
        if (n !== H0 - 1) begin
            n_bad++;
            $display("FAIL pause_fetch_resume: got %0d HI cycles required %0d", n, H0 - 1);
        end
    endtask

    task automatic test_tape_end_change();
        mem[0] = 8'($urandom);
        mem[1] = 8'($urandom);
        te_a = '0;
        build(1, 0, 100000);
        run("tape_end_change", 0, 1, -1, 0, 50, AW'(1));
    endtask

    task automatic test_rewind();
        mem[0] = 8'($urandom);
        mem[1] = 8'($urandom);
        te_a = AW'(1);
        build(1, 0, 60);
        run("rewind_pre", 0, 1, -1, 0, -1, '0);
        rw_a = 1'b1;
        @(negedge clk);
        n_cmp++; if (addr_a !== '0) begin n_bad++; $display("FAIL rewind_addr: got %0d required 0", addr_a); end
        n_cmp++; if (busy_a !== 1'b0) begin n_bad++; $display("FAIL rewind_busy: got %b required 0", busy_a); end
        n_cmp++; if (data_a !== 1'b0) begin n_bad++; $display("FAIL rewind_data: got %b required 0", data_a); end
        build(1, 0, 100000);
        run("rewind_replay", 0, 0, -1, 0, -1, '0);
    endtask

    task automatic test_loop();
        for (int a = 0; a < 3; a++) mem[a] = 8'($urandom);
        te_b = AW'(2);
        build(2, 1, 1400);
        run("loop", 1, 1, -1, 0, -1, '0);
    endtask

    task automatic test_async_reset();
        int   n = 0;
        rec_t oa, ob;
        @(negedge clk);
        rw_a = 1'b1;
        en_a = 1'b1;
        te_a = '0;
        @(negedge clk);
        rw_a = 1'b0;
        while (!(data_a === 1'b0 && busy_a === 1'b1) && n < 500) begin
            n++;
            @(negedge clk);
        end
        n_cmp++;
        if (n >= 500) begin
            n_bad++;
            $display("FAIL async_reset_reach_lo: got timeout after %0d cycles required LO phase", n);
        end else begin
            #2 reset = 1'b1;
            #1;
            oa = get_obs(0);
            ob = get_obs(1);
            n_cmp++;
            if (oa !== mk(0, 0, 0, 0)) begin
                n_bad++;
                $display("FAIL async_reset_a: got d/b/a/e=%b/%b/%0d/%b required 0/0/0/0", oa.d, oa.b, oa.a, oa.e);
            end
            n_cmp++;
            if (ob !== mk(0, 0, 0, 0)) begin
                n_bad++;
                $display("FAIL async_reset_b: got d/b/a/e=%b/%b/%0d/%b required 0/0/0/0", ob.d, ob.b, ob.a, ob.e);
            end
            @(negedge clk);
            reset = 1'b0;
        end
    endtask

    initial begin
        for (int a = 0; a < 16; a++) mem[a] = 8'h00;
        test_reset();
        test_single_byte();
        test_timing();
        test_random_tapes();
        test_pause();
        test_pause_fetch();
        test_tape_end_change();
        test_rewind();
        test_loop();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
